trace_rst_sequencer: RTL and testbench
======================================

TRACE_RST_SEQUENCER -- requirements
Module: trace_rst_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 3, meaning cycles from synchronized reset release to trace enable.
REQ-002 SHALL have parameter DRAIN_TIMEOUT, default 16, meaning maximum DRAIN cycles while agent_busy is high.
REQ-003 SHALL have parameter CNT_W, default 64, meaning clkcnt width.
REQ-004 SHALL have port clk, input, 1, the single clock; all state is on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have port stop_req, input, 1, level request to end tracing.
REQ-007 SHALL have port agent_busy, input, 1, OR of downstream trace agents still writing.
REQ-008 SHALL have port rst_sync_n, output, 1, reset with asynchronous assert and synchronous deassert.
REQ-009 SHALL have port trace_en, output, 1, high while the state is ACTIVE.
REQ-010 SHALL have port trace_start, output, 1, one-cycle pulse in the first ACTIVE cycle.
REQ-011 SHALL have port trace_stop, output, 1, one-cycle pulse in the first DONE cycle.
REQ-012 SHALL have port clkcnt, output, CNT_W, cycles elapsed since rst_sync_n rose.
REQ-013 SHALL have port state, output, 3, encoding IDLE=0, SETTLE=1, ACTIVE=2, DRAIN=3, DONE=4.
REQ-014 SHALL have port timeout_err, output, 1, sticky drain-timeout flag.

Function
REQ-015 rst_sync_n SHALL come from a 2-flop synchronizer and rise on the 2nd rising clk edge after rst deasserts.
REQ-016 clkcnt SHALL be 0 while rst_sync_n=0, increment by 1 on every edge with rst_sync_n=1, and saturate at all-ones without wrapping.
REQ-017 IDLE SHALL be held while rst_sync_n=0; on the first cycle with rst_sync_n=1 it SHALL go to SETTLE, or to ACTIVE if SETTLE_CYCLES=0.
REQ-018 SETTLE SHALL last exactly SETTLE_CYCLES cycles, tracked by a counter cleared on entry, then go to ACTIVE.
REQ-019 stop_req seen in IDLE or SETTLE SHALL set stop_pend.
REQ-020 When stop_pend is set, ACTIVE SHALL last exactly one cycle and then go to DRAIN.
REQ-021 In ACTIVE, stop_req=1 SHALL move to DRAIN on the next edge; trace_en SHALL drop in the same cycle DRAIN is entered.
REQ-022 In DRAIN, agent_busy=0 SHALL move to DONE on the next edge, including in the first DRAIN cycle.
REQ-023 DONE SHALL be terminal until rst asserts; stop_req and agent_busy SHALL be ignored in DONE.
REQ-024 trace_start and trace_stop SHALL be registered, exactly one cycle wide, and SHALL occur once per reset epoch.
REQ-025 stop_req and agent_busy SHALL be treated as synchronous to clk.

Reset
REQ-026 Asserting rst at any time, including mid-DRAIN, SHALL asynchronously force: state=IDLE, rst_sync_n=0, trace_en=0, trace_start=0, trace_stop=0, clkcnt=0, timeout_err=0, stop_pend=0, all internal counters=0.
REQ-027 After rst deasserts, operation SHALL restart from REQ-015 with no memory of the previous epoch.

Configuration
REQ-028 With macro TRACE_RST_SEQUENCER_TIMEOUT_EN defined, a drain counter SHALL run in DRAIN; after DRAIN_TIMEOUT cycles with agent_busy still 1, the block SHALL go to DONE and set timeout_err=1 until reset.
REQ-029 With TRACE_RST_SEQUENCER_TIMEOUT_EN undefined, DRAIN SHALL wait indefinitely for agent_busy=0, timeout_err SHALL be tied to 0, and the drain counter SHALL not exist.

Verification
REQ-030 Release rst at edge 0, SETTLE_CYCLES=3 -> rst_sync_n=1 at edge 2; state IDLE->SETTLE at edge 3; ACTIVE and trace_start at edge 6; clkcnt=4 at edge 6.
REQ-031 SETTLE_CYCLES=0 -> IDLE goes directly to ACTIVE one edge after rst_sync_n rises, with trace_start pulsed.
REQ-032 stop_req pulsed during SETTLE, agent_busy=0 -> exactly one ACTIVE cycle, one DRAIN cycle, then DONE with trace_stop pulsed once.
REQ-033 In ACTIVE, stop_req=1 with agent_busy high for 5 cycles -> DRAIN lasts 6 cycles, then DONE, timeout_err=0.
REQ-034 Macro defined, DRAIN_TIMEOUT=16, agent_busy stuck at 1 -> DONE after 16 DRAIN cycles, timeout_err=1 and sticky; macro undefined -> state stays DRAIN for 1000 cycles.
REQ-035 rst asserted mid-DRAIN between clock edges -> all outputs reach reset values without a clock edge; CNT_W=4 run -> clkcnt holds at 15.

Source files
------------

// File: rtl/trace_rst_sequencer.sv
// Trace reset sequencer: reset synchronizer, free-running cycle counter and the
// IDLE/SETTLE/ACTIVE/DRAIN/DONE trace lifecycle. Drain timeout: TRACE_RST_SEQUENCER_TIMEOUT_EN.
module trace_rst_sequencer #(
    parameter int SETTLE_CYCLES = 3,
    parameter int DRAIN_TIMEOUT = 16,
    parameter int CNT_W         = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stop_req,
    input  logic             agent_busy,
    output logic             rst_sync_n,
    output logic             trace_en,
    output logic             trace_start,
    output logic             trace_stop,
    output logic [CNT_W-1:0] clkcnt,
    output logic [2:0]       state,
    output logic             timeout_err
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_ACTIVE = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    state_e             state_q, state_d;
    logic               sync1_q, sync1_d;
    logic               sync2_q, sync2_d;
    logic [SET_W-1:0]   settle_cnt_q, settle_cnt_d;
    logic               stop_pend_q, stop_pend_d;
    logic [CNT_W-1:0]   clkcnt_q, clkcnt_d;
    logic               trace_en_q, trace_en_d;
    logic               trace_start_q, trace_start_d;
    logic               trace_stop_q, trace_stop_d;
    logic               timeout_err_q, timeout_err_d;
    logic               settle_last;

`ifdef TRACE_RST_SEQUENCER_TIMEOUT_EN
    localparam int DR_W = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
    logic [DR_W-1:0]    drain_cnt_q, drain_cnt_d;
    logic               drain_last;
    assign drain_last = (int'(drain_cnt_q) == DRAIN_TIMEOUT - 1);
`endif

    assign settle_last = (int'(settle_cnt_q) == SETTLE_CYCLES - 1);

    always_comb begin
        // NOTE: every variable gets its default first so no path can infer a latch.
        state_d       = state_q;
        sync1_d       = 1'b1;
        sync2_d       = sync1_q;
        settle_cnt_d  = settle_cnt_q;
        stop_pend_d   = stop_pend_q;
        clkcnt_d      = clkcnt_q;
        timeout_err_d = timeout_err_q;
`ifdef TRACE_RST_SEQUENCER_TIMEOUT_EN
        drain_cnt_d   = drain_cnt_q;
`endif

        // Saturating count of cycles since the synchronized reset released.
        if (sync2_q && (clkcnt_q != '1)) clkcnt_d = clkcnt_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (stop_req) stop_pend_d = 1'b1;
                if (sync2_q) begin
                    settle_cnt_d = '0;
                    state_d      = (SETTLE_CYCLES == 0) ? ST_ACTIVE : ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (stop_req) stop_pend_d = 1'b1;
                if (settle_last) state_d = ST_ACTIVE;
                else             settle_cnt_d = settle_cnt_q + 1'b1;
            end
            ST_ACTIVE: begin
                if (stop_pend_q || stop_req) begin
                    state_d = ST_DRAIN;
`ifdef TRACE_RST_SEQUENCER_TIMEOUT_EN
                    drain_cnt_d = '0;
`endif
                end
            end
            ST_DRAIN: begin
                if (!agent_busy) begin
                    state_d = ST_DONE;
                end
`ifdef TRACE_RST_SEQUENCER_TIMEOUT_EN
                else if (drain_last) begin
                    state_d       = ST_DONE;
                    timeout_err_d = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
`endif
            end
            ST_DONE:  state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase

        // Outputs are registered from the next state so they align with it.
        trace_en_d    = (state_d == ST_ACTIVE);
        trace_start_d = (state_d == ST_ACTIVE) && (state_q != ST_ACTIVE);
        trace_stop_d  = (state_d == ST_DONE) && (state_q != ST_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst) begin
            state_q       <= ST_IDLE;
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            settle_cnt_q  <= '0;
            stop_pend_q   <= 1'b0;
            clkcnt_q      <= '0;
            trace_en_q    <= 1'b0;
            trace_start_q <= 1'b0;
            trace_stop_q  <= 1'b0;
            timeout_err_q <= 1'b0;
`ifdef TRACE_RST_SEQUENCER_TIMEOUT_EN
            drain_cnt_q   <= '0;
`endif
        end else begin
            state_q       <= state_d;
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            settle_cnt_q  <= settle_cnt_d;
            stop_pend_q   <= stop_pend_d;
            clkcnt_q      <= clkcnt_d;
            trace_en_q    <= trace_en_d;
            trace_start_q <= trace_start_d;
            trace_stop_q  <= trace_stop_d;
            timeout_err_q <= timeout_err_d;
`ifdef TRACE_RST_SEQUENCER_TIMEOUT_EN
            drain_cnt_q   <= drain_cnt_d;
`endif
        end
    end

    assign rst_sync_n  = sync2_q;
    assign trace_en    = trace_en_q;
    assign trace_start = trace_start_q;
    assign trace_stop  = trace_stop_q;
    assign clkcnt      = clkcnt_q;
    assign state       = state_q;
`ifdef TRACE_RST_SEQUENCER_TIMEOUT_EN
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_trace_rst_sequencer.sv
// Testbench for trace_rst_sequencer: randomized reset epochs checked against a
// segment-length timeline model; extra instances cover SETTLE_CYCLES=0 and CNT_W=4.
module tb_trace_rst_sequencer;

    localparam int S  = 3;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stop_req = 1'b0;
    logic        agent_busy = 1'b0;

    logic        rst_sync_n, trace_en, trace_start, trace_stop, timeout_err;
    logic [63:0] clkcnt;
    logic [2:0]  state;

    logic        z_rst_sync_n, z_trace_en, z_trace_start, z_trace_stop, z_timeout_err;
    logic [63:0] z_clkcnt;
    logic [2:0]  z_state;

    logic        c_rst_sync_n, c_trace_en, c_trace_start, c_trace_stop, c_timeout_err;
    logic [3:0]  c_clkcnt;
    logic [2:0]  c_state;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int cur_k   = -1;

    trace_rst_sequencer #(.SETTLE_CYCLES(S), .DRAIN_TIMEOUT(TO), .CNT_W(64)) dut (
        .clk(clk), .rst(rst), .stop_req(stop_req), .agent_busy(agent_busy),
        .rst_sync_n(rst_sync_n), .trace_en(trace_en), .trace_start(trace_start),
        .trace_stop(trace_stop), .clkcnt(clkcnt), .state(state), .timeout_err(timeout_err)
    );

    trace_rst_sequencer #(.SETTLE_CYCLES(0), .DRAIN_TIMEOUT(TO), .CNT_W(64)) dut_z (
        .clk(clk), .rst(rst), .stop_req(stop_req), .agent_busy(agent_busy),
        .rst_sync_n(z_rst_sync_n), .trace_en(z_trace_en), .trace_start(z_trace_start),
        .trace_stop(z_trace_stop), .clkcnt(z_clkcnt), .state(z_state), .timeout_err(z_timeout_err)
    );

    trace_rst_sequencer #(.SETTLE_CYCLES(S), .DRAIN_TIMEOUT(TO), .CNT_W(4)) dut_c (
        .clk(clk), .rst(rst), .stop_req(stop_req), .agent_busy(agent_busy),
        .rst_sync_n(c_rst_sync_n), .trace_en(c_trace_en), .trace_start(c_trace_start),
        .trace_stop(c_trace_stop), .clkcnt(c_clkcnt), .state(c_state), .timeout_err(c_timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, cur_k, obs, exp);
        end
    endtask

    task automatic check_reset(string where);
        check({where, "_state"},       64'(state),        64'd0);
        check({where, "_rst_sync_n"},  64'(rst_sync_n),   64'd0);
        check({where, "_trace_en"},    64'(trace_en),     64'd0);
        check({where, "_trace_start"}, 64'(trace_start),  64'd0);
        check({where, "_trace_stop"},  64'(trace_stop),   64'd0);
        check({where, "_clkcnt"},      clkcnt,            64'd0);
        check({where, "_timeout_err"}, 64'(timeout_err),  64'd0);
        check({where, "_c_clkcnt"},    64'(c_clkcnt),     64'd0);
        check({where, "_z_state"},     64'(z_state),      64'd0);
    endtask

    // State after edge k, from segment boundaries: IDLE [0,3), SETTLE [3,a0),
    // ACTIVE [a0,d0), DRAIN [d0,dn), DONE from dn on.
    function automatic int exp_state(int k, int a0, int d0, int dn);
        if (k < 3)  return 0;
        if (k < a0) return 1;
        if (k < d0) return 2;
        if (k < dn) return 3;
        return 4;
    endfunction

    // One reset epoch. sis: stop pulse during IDLE/SETTLE; l: ACTIVE cycle in
    // which stop_req is raised; b: DRAIN cycles with agent_busy high;
    // rst_at: cycle at which rst is asserted mid-cycle (-1 = end of epoch).
    task automatic run_epoch(bit sis, int l, int b, int tail, int rst_at);
        int  a0, la, d0, ld, dn, n, last, spos, es, ecnt;
        bit  err;
        a0   = 3 + S;
        la   = sis ? 1 : l;
        d0   = a0 + la;
`ifdef TRACE_RST_SEQUENCER_TIMEOUT_EN
        ld   = (b >= TO) ? TO : b + 1;
        err  = (b >= TO);
`else
        ld   = b + 1;
        err  = 1'b0;
`endif
        dn   = d0 + ld;
        n    = dn + tail;
        last = (rst_at >= 0) ? rst_at : n - 1;
        spos = int'($urandom_range(0, 2 + S));

        @(posedge clk); #1;
        cur_k = -1;
        check_reset("held");
        @(posedge clk); #1;
        rst = 1'b1;

        for (int k = 0; k <= last; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            cur_k = k;
            es    = exp_state(k, a0, d0, dn);
            ecnt  = (k >= 2) ? k - 2 : 0;
            check("state",       64'(state),       64'(es));
            check("rst_sync_n",  64'(rst_sync_n),  64'(k >= 2));
            check("clkcnt",      clkcnt,           64'(ecnt));
            check("trace_en",    64'(trace_en),    64'(es == 2));
            check("trace_start", 64'(trace_start), 64'(k == a0));
            check("trace_stop",  64'(trace_stop),  64'(k == dn));
            check("timeout_err", 64'(timeout_err), 64'(err && k >= dn));
            check("c_clkcnt",    64'(c_clkcnt),    64'((ecnt > 15) ? 15 : ecnt));
            if (k == 2) check("z_state_idle", 64'(z_state), 64'd0);
            if (k == 3) begin
                check("z_state_active", 64'(z_state),       64'd2);
                check("z_trace_start",  64'(z_trace_start), 64'd1);
            end
            if (k == 4) check("z_trace_start_off", 64'(z_trace_start), 64'd0);

            if (k < a0)      stop_req = sis && (k == spos);
            else if (k < d0) stop_req = sis ? 1'($urandom) : (k == a0 + l - 1);
            else             stop_req = 1'($urandom);
            if (k < d0)           agent_busy = 1'($urandom);
            else if (k < d0 + b)  agent_busy = 1'b1;
            else if (k == d0 + b) agent_busy = 1'b0;
            else                  agent_busy = 1'($urandom);
        end

        #2 rst = 1'b0;
        #1 check_reset("async");
        stop_req   = 1'b0;
        agent_busy = 1'b0;
    endtask

    initial begin
        run_epoch(1'b0, 4, 5, 15, -1);
        run_epoch(1'b1, 3, 0, 15, -1);
        for (int e = 0; e < 8; e++)
            run_epoch(1'($urandom), int'($urandom_range(1, 8)), int'($urandom_range(0, 10)),
                      int'($urandom_range(2, 20)), -1);
        run_epoch(1'b0, 2, 30, 5, 11);
        run_epoch(1'b0, 5, 2, 15, -1);
`ifdef TRACE_RST_SEQUENCER_TIMEOUT_EN
        run_epoch(1'b0, 1, 40, 10, -1);
`else
        run_epoch(1'b0, 1, 1000, 3, -1);
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
